// File: rtl/piso_serializer_if.sv
// piso_serializer_if
//   Handshake and serial-stream bundle for piso_serializer.
//   The upstream word source and the downstream SISO consumer connect
//   through the master modport; the serializer uses the slave modport.
//
//   direction    1 = MSB-first, 0 = LSB-first (sampled on word accept)
//   din          parallel word
//   din_valid    din holds a word to send
//   din_ready    serializer can take a word this cycle
//   sout         registered serial bit, feeds the SISO sin
//   sout_valid   sout carries a frame bit
//   frame_start  sout is the first bit of a frame
//   frame_end    sout is the last bit of a frame
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             direction;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_end;

    modport master (
        output direction, din, din_valid,
        input  din_ready, sout, sout_valid, frame_start, frame_end
    );

    modport slave (
        input  direction, din, din_valid,
        output din_ready, sout, sout_valid, frame_start, frame_end
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in, serial-out stage. Takes one WIDTH-bit word per valid/ready
//   handshake and emits it one bit per clock, MSB-first or LSB-first, with
//   an optional trailing even-parity bit. Consecutive words stream with no
//   idle cycle between frames.
//
//   Parameters
//     WIDTH   data word width (2 or more)
//     PARITY  0 = WIDTH-bit frame, 1 = WIDTH+1-bit frame ending in parity
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   piso_serializer_if slave: direction/din/din_valid/din_ready in
//           the word handshake, sout/sout_valid/frame_start/frame_end out
module piso_serializer #(
    parameter int WIDTH  = 8,
    parameter int PARITY = 0
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);

    localparam int N  = WIDTH + PARITY;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [CW-1:0] PAR_SLOT = CW'(WIDTH);
    localparam logic [CW-1:0] TOP_BIT  = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_next;
    logic             dir_q;
    logic             dir_next;
    logic             par_q;
    logic             par_next;
    logic             load;
    logic             ready;
    logic             accept;
    logic [IW-1:0]    bit_idx;
    logic             sout_q;
    logic             sout_next;
    logic             valid_q;
    logic             valid_next;
    logic             start_q;
    logic             start_next;
    logic             end_q;
    logic             end_next;

    // Ready depends only on state and counter so the upstream can never
    // form a combinational loop through din_valid. The last-bit cycle of a
    // frame is also a ready cycle, which is what lets frames run gap-free.
    always_comb begin
        ready  = !rst && ((state == IDLE) || ((state == SHIFT) && (count == LAST)));
        accept = bus.din_valid && ready;
    end

    // Next-state logic. A word loaded on the last bit of a frame keeps the
    // FSM in SHIFT and restarts the counter, so the next frame follows
    // directly.
    always_comb begin
        state_next = state;
        count_next = count;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    count_next = '0;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (count == LAST) begin
                    count_next = '0;
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Word, order and parity are captured only on accept; anything the
    // upstream does to din or direction between accepts is ignored.
    always_comb begin
        word_next = load ? bus.din       : word_q;
        dir_next  = load ? bus.direction : dir_q;
        par_next  = load ? (^bus.din)    : par_q;
    end

    // The outputs are registered, so the bit that will be visible next
    // cycle is selected from the next-cycle state, counter and word.
    always_comb begin
        sout_next  = 1'b0;
        valid_next = 1'b0;
        start_next = 1'b0;
        end_next   = 1'b0;
        bit_idx    = '0;
        if (state_next == SHIFT) begin
            valid_next = 1'b1;
            start_next = (count_next == '0);
            end_next   = (count_next == LAST);
            if ((PARITY != 0) && (count_next == PAR_SLOT)) begin
                sout_next = par_next;
            end else begin
                if (dir_next) begin
                    bit_idx = IW'(TOP_BIT - count_next);
                end else begin
                    bit_idx = IW'(count_next);
                end
                sout_next = word_next[bit_idx];
            end
        end
    end

    // State and datapath registers. Reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
            par_q   <= 1'b0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            word_q  <= word_next;
            dir_q   <= dir_next;
            par_q   <= par_next;
            sout_q  <= sout_next;
            valid_q <= valid_next;
            start_q <= start_next;
            end_q   <= end_next;
        end
    end

    assign bus.din_ready   = ready;
    assign bus.sout        = sout_q;
    assign bus.sout_valid  = valid_q;
    assign bus.frame_start = start_q;
    assign bus.frame_end   = end_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
//   Drives two serializers side by side from one clock: dut0 with PARITY=0
//   and dut1 with PARITY=1, both WIDTH=8. Each has its own word queue and a
//   reference model that expands an accepted word into the list of bits it
//   must produce, then compares the stream cycle by cycle.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din_v [2];
    logic       dir_v [2];
    logic       val_v [2];

    piso_serializer_if #(.WIDTH(8)) bus0 ();
    piso_serializer_if #(.WIDTH(8)) bus1 ();

    assign bus0.din       = din_v[0];
    assign bus0.direction = dir_v[0];
    assign bus0.din_valid = val_v[0];
    assign bus1.din       = din_v[1];
    assign bus1.direction = dir_v[1];
    assign bus1.din_valid = val_v[1];

    piso_serializer #(.WIDTH(8), .PARITY(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    piso_serializer #(.WIDTH(8), .PARITY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Model state: cur holds {bit,start,end} visible this cycle, pend the
    // bits still to come; acc records that the last edge took a word.
    logic [2:0] pend0 [$];
    logic [2:0] pend1 [$];
    logic [2:0] cur   [2];
    logic       curv  [2];
    logic       acc   [2];
    logic [8:0] words0 [$];
    logic [8:0] words1 [$];

    task automatic compare(input string tag, input int d, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, d, $time, obs, exp);
        end
    endtask

    // Expands one word into its frame: data bits in the chosen order, then
    // the even-parity bit for the parity variant.
    task automatic pushFrame(input int d, input logic [7:0] w, input logic dir);
        int         n;
        int         idx;
        logic       b;
        logic [2:0] rec;
        n = 8 + d;
        for (int i = 0; i < n; i++) begin
            if (i == 8) begin
                b = (($countones(w) % 2) != 0);
            end else begin
                idx = dir ? (7 - i) : i;
                b   = w[3'(idx)];
            end
            rec = {b, (i == 0), (i == n - 1)};
            if (d == 0) pend0.push_back(rec);
            else        pend1.push_back(rec);
        end
    endtask

    // Advances the model across one rising edge using the inputs that the
    // DUTs see on that same edge.
    task automatic modelUpdate();
        logic er;
        int   sz;
        for (int d = 0; d < 2; d++) begin
            er     = !rst && (!curv[d] || cur[d][0]);
            acc[d] = 1'b0;
            if (rst) begin
                if (d == 0) pend0.delete();
                else        pend1.delete();
                cur[d]  = 3'b000;
                curv[d] = 1'b0;
            end else begin
                if (val_v[d] && er) begin
                    acc[d] = 1'b1;
                    pushFrame(d, din_v[d], dir_v[d]);
                end
                sz = (d == 0) ? pend0.size() : pend1.size();
                if (sz > 0) begin
                    cur[d]  = (d == 0) ? pend0.pop_front() : pend1.pop_front();
                    curv[d] = 1'b1;
                end else begin
                    cur[d]  = 3'b000;
                    curv[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput(input int d);
        logic o_v, o_b, o_s, o_e, o_r, e_r;
        if (d == 0) begin
            o_v = bus0.sout_valid; o_b = bus0.sout;
            o_s = bus0.frame_start; o_e = bus0.frame_end; o_r = bus0.din_ready;
        end else begin
            o_v = bus1.sout_valid; o_b = bus1.sout;
            o_s = bus1.frame_start; o_e = bus1.frame_end; o_r = bus1.din_ready;
        end
        e_r = !rst && (!curv[d] || cur[d][0]);
        compare("sout_valid", d, o_v, curv[d]);
        compare("sout", d, o_b, cur[d][2]);
        compare("frame_start", d, o_s, cur[d][1]);
        compare("frame_end", d, o_e, cur[d][0]);
        compare("din_ready", d, o_r, e_r);
    endtask

    // Presents the head of each word queue, optionally with random idle
    // cycles; idle inputs carry random din/direction that must be ignored.
    task automatic applyStimulus(input bit gaps);
        logic [8:0] head;
        int         sz;
        for (int d = 0; d < 2; d++) begin
            sz = (d == 0) ? words0.size() : words1.size();
            if (sz > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                head     = (d == 0) ? words0[0] : words1[0];
                val_v[d] = 1'b1;
                din_v[d] = head[7:0];
                dir_v[d] = head[8];
            end else begin
                val_v[d] = 1'b0;
                din_v[d] = 8'($urandom);
                dir_v[d] = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic sendWords(input bit gaps);
        int budget;
        budget = 0;
        while ((words0.size() > 0 || words1.size() > 0) && budget < 600) begin
            applyStimulus(gaps);
            tick();
            if (acc[0]) void'(words0.pop_front());
            if (acc[1]) void'(words1.pop_front());
            budget++;
        end
        if (budget >= 600) begin
            total++;
            fails++;
            $display("[TB] FAIL send_budget observed=%0d cycles required=<600", budget);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0);
            tick();
        end
    endtask

    task automatic queueBoth(input logic dir, input logic [7:0] w);
        words0.push_back({dir, w});
        words1.push_back({dir, w});
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cur[d]   = 3'b000;
            curv[d]  = 1'b0;
            acc[d]   = 1'b0;
            val_v[d] = 1'b1;
            din_v[d] = 8'hB4;
            dir_v[d] = 1'b1;
        end

        // Reset held for two edges with din_valid high: nothing is taken.
        rst = 1'b1;
        @(posedge clk);
        modelUpdate();
        #1;
        tick();
        rst = 1'b0;
        drain(2);

        // MSB-first single word.
        queueBoth(1'b1, 8'hB4);
        sendWords(1'b0);
        drain(11);

        // LSB-first; drain randomizes din/direction mid-frame.
        queueBoth(1'b0, 8'hB4);
        sendWords(1'b0);
        drain(11);

        // Back-to-back frames under continuous valid.
        queueBoth(1'b1, 8'hB4);
        queueBoth(1'b1, 8'h0F);
        sendWords(1'b0);
        drain(11);

        // Parity values 0 and 1 on the PARITY=1 instance.
        queueBoth(1'b1, 8'hB4);
        queueBoth(1'b1, 8'hB5);
        sendWords(1'b0);
        drain(11);

        // Reset mid-frame, then a clean restart.
        queueBoth(1'b1, 8'hB4);
        sendWords(1'b0);
        drain(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drain(2);
        queueBoth(1'b1, 8'hB4);
        sendWords(1'b0);
        drain(11);

        // Random words, random order, random idle gaps.
        for (int i = 0; i < 24; i++) begin
            words0.push_back(9'($urandom));
            words1.push_back(9'($urandom));
        end
        sendWords(1'b1);
        drain(12);

        $display("[TB] errors seen: %0d", fails);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
